fx3_burst_reader: RTL and testbench
===================================

// Module: fx3_burst_reader
// PURPOSE
// - Read side of the ADC sample FIFO, running entirely in the FX3 clock domain.
// - Waits for the FIFO data-available flag and an FX3 DMA-ready flag, then drains one fixed-length burst.
// - Forwards the 16-bit signed sample words onto the FX3 GPIF data bus with a write strobe.
// - Aborts and ends the packet cleanly if the FIFO runs dry mid-burst.
// PARAMETERS
// - BURST_LEN     8192  words per burst; equals the FIFO data-available threshold.
// - READ_LATENCY  2     fx3Clk cycles from readData high to valid fifoData (FIFO q plus 10->16 converter register).
// - CNT_W         14    burst counter width; must satisfy 2**CNT_W > BURST_LEN.
// PORTS
// - fx3Clk          in   1   single clock for the block.
// - reset           in   1   asynchronous, active-high reset.
// - enable          in   1   capture running; new bursts start only while high.
// - dataAvailable   in   1   FIFO holds more than BURST_LEN-1 words.
// - fifoEmpty       in   1   FIFO read-side empty flag.
// - fifoData        in   16  converted sample; valid READ_LATENCY cycles after readData.
// - fx3Ready        in   1   FX3 DMA buffer ready for a whole burst.
// - readData        out  1   FIFO read request.
// - fx3Wr           out  1   fx3Data is valid this cycle.
// - fx3Data         out  16  sample word to the GPIF bus.
// - fx3PktEnd       out  1   one-cycle short-packet end strobe.
// - busy            out  1   high in every state except IDLE.
// - underflowError  out  1   sticky flag; cleared only by reset.
// BEHAVIOUR
// - Reset (async, mid-operation included):
//   - all outputs 0, FSM to IDLE, burst counter 0, latency pipe cleared.
//   - The effect is immediate and does not wait for a clock edge.
// - FSM states: IDLE -> BURST -> DRAIN -> (END) -> IDLE.
//   - IDLE: go to BURST on the edge where enable && dataAvailable && fx3Ready.
//   - BURST: readData = !fifoEmpty. Counter increments on every word issued.
//     - On the edge where the BURST_LEN-th readData is issued: go to DRAIN.
//     - If fifoEmpty is seen in BURST: readData stays 0 that cycle, underflowError is set, and the FSM goes to DRAIN with the abort flag set.
//   - DRAIN: wait READ_LATENCY+1 cycles so in-flight words still emerge.
//     - Then go to END if the abort flag is set, otherwise to IDLE.
//   - END: fx3PktEnd=1 for exactly one cycle, one cycle after the last fx3Wr; then go to IDLE.
// - Burst conditions:
//   - fx3Ready and dataAvailable are sampled only at burst start and are ignored during BURST.
//   - enable falling mid-burst does not truncate the burst; no new burst starts afterwards.
// - Datapath:
//   - readData is delayed by a READ_LATENCY-deep shift register; its tap qualifies fifoData.
//   - fx3Data/fx3Wr are registered, so a word appears READ_LATENCY+1 cycles after its readData.
//   - fx3Data holds its last value when fx3Wr=0. No width conversion: fifoData passes through bit-exact.
// - Burst accounting:
//   - A full burst gives exactly BURST_LEN fx3Wr pulses with no fx3PktEnd.
//   - An aborted burst gives N<BURST_LEN pulses and then one fx3PktEnd.
// - Back-to-back bursts:
//   - At least READ_LATENCY+2 idle cycles separate the last readData of one burst from the first readData of the next.
// CONFIGURATION
// - FX3_SEQUENCE_CHECK_EN defined: adds output seqError (1 bit, sticky, reset 0).
//   - Within a burst, seqError sets when a forwarded word is not previous+1 modulo 2**10, compared in the converted 16-bit domain.
//   - This checks the generator's incrementing test-mode counter.
//   - The first word of each burst only loads the comparator.
// - FX3_SEQUENCE_CHECK_EN undefined: no seqError port and no checker logic.
// TESTING
// - Full burst: BURST_LEN=16, FIFO preloaded with 32 words, dataAvailable=1, fx3Ready=1.
//   - readData high 16 consecutive cycles; 16 fx3Wr pulses starting 3 cycles later.
//   - Data is in order; fx3PktEnd stays 0.
// - Gating: dataAvailable=1, fx3Ready=0 for 50 cycles, then 1.
//   - No readData during the 50 cycles; the burst starts on the edge after fx3Ready rises.
// - Underflow: BURST_LEN=16, FIFO holds 5 words, fifoEmpty rises after the 5th read.
//   - 5 fx3Wr pulses; underflowError=1; a single fx3PktEnd one cycle after the 5th fx3Wr.
// - Reset mid-burst: assert reset at word 7.
//   - readData, fx3Wr, busy and underflowError drop to 0 immediately.
//   - After release, the FSM is in IDLE until the next start condition.
// - enable drop: deassert enable at word 4 of a 16-word burst.
//   - All 16 words are still forwarded; no second burst starts while dataAvailable stays 1.
// - FX3_SEQUENCE_CHECK_EN: feed 0,1,2,4.
//   - seqError rises with the word 4 fx3Wr and stays high.
//   - Feeding 1023,0 (in the converted domain) leaves seqError at 0.

Source files
------------

// File: rtl/fx3_burst_reader.sv
// fx3_burst_reader: read side of the ADC sample FIFO in the FX3 clock domain.
// Waits for FIFO data-available and FX3 DMA-ready, drains one fixed-length
// burst onto the GPIF bus, and ends the packet early if the FIFO runs dry.
// Optional feature macro: FX3_SEQUENCE_CHECK_EN adds the sticky seqError_o
// output that checks the generator's incrementing test-mode counter.
//
// Handshake semantics: there is no back-pressure anywhere in this block.
// readData_o is a one-cycle read request that the FIFO always honours, and
// fx3Wr_o marks fx3Data_o as valid for exactly the cycles it is high; the
// FX3 side has promised room for the whole burst by raising fx3Ready_i.
module fx3_burst_reader #(
   parameter int BURST_LEN    = 8192,
   parameter int READ_LATENCY = 2,
   parameter int CNT_W        = 14
) (
   input  logic        fx3Clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        dataAvailable_i,
   input  logic        fifoEmpty_i,
   input  logic [15:0] fifoData_i,
   input  logic        fx3Ready_i,
   output logic        readData_o,
   output logic        fx3Wr_o,
   output logic [15:0] fx3Data_o,
   output logic        fx3PktEnd_o,
   output logic        busy_o,
   output logic        underflowError_o,
`ifdef FX3_SEQUENCE_CHECK_EN
   output logic        seqError_o,
`endif
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DRAIN = 2'd2,
      S_END   = 2'd3
   } state_t;

   localparam int DRN_W = $clog2(READ_LATENCY + 2);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);
   // A clean burst waits READ_LATENCY+1 cycles after its last read. On an
   // abort the BURST cycle that saw fifoEmpty already counts as one of them,
   // which puts the packet-end strobe right after the last forwarded word.
   localparam logic [DRN_W-1:0] DRAIN_FULL  = DRN_W'(READ_LATENCY);
   localparam logic [DRN_W-1:0] DRAIN_ABORT = DRN_W'(READ_LATENCY - 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DRN_W-1:0]        drain_q, drain_d;
   logic                    abort_q, abort_d;
   logic                    und_q, und_d;
   logic [READ_LATENCY-1:0] pipe_q, pipe_d;
   logic                    wr_q;
   logic [15:0]             data_q;
   logic                    tap;
   logic                    drain_done;

   assign tap        = pipe_q[READ_LATENCY-1];
   assign drain_done = (drain_q == (abort_q ? DRAIN_ABORT : DRAIN_FULL));

   // State register
   always_ff @(posedge fx3Clk_i or posedge reset_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic: start condition sampled only in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (enable_i && dataAvailable_i && fx3Ready_i) state_d = S_BURST;
         S_BURST: if (fifoEmpty_i || (cnt_q == LAST_WORD)) state_d = S_DRAIN;
         S_DRAIN: if (drain_done) state_d = abort_q ? S_END : S_IDLE;
         S_END:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: read request, packet end, busy and debug state
   always_comb begin
      readData_o  = (state_q == S_BURST) && !fifoEmpty_i;
      fx3PktEnd_o = (state_q == S_END);
      busy_o      = (state_q != S_IDLE);
      state_o     = state_q;
   end

   // Burst/drain counters, abort flag and sticky underflow
   always_comb begin
      cnt_d   = cnt_q;
      drain_d = drain_q;
      abort_d = abort_q;
      und_d   = und_q;
      case (state_q)
         S_IDLE: begin
            cnt_d   = '0;
            drain_d = '0;
            abort_d = 1'b0;
         end
         S_BURST: begin
            if (fifoEmpty_i) begin
               abort_d = 1'b1;
               und_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN: drain_d = drain_q + 1'b1;
         default: ;
      endcase
   end

   // Read-latency shift register: its tap marks fifoData_i as a real word
   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = readData_o;
      for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
   end

   // Counters, pipe and registered GPIF outputs
   always_ff @(posedge fx3Clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q   <= '0;
         drain_q <= '0;
         abort_q <= 1'b0;
         und_q   <= 1'b0;
         pipe_q  <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
         abort_q <= abort_d;
         und_q   <= und_d;
         pipe_q  <= pipe_d;
         wr_q    <= tap;
         if (tap) data_q <= fifoData_i;
      end
   end

   assign fx3Wr_o          = wr_q;
   assign fx3Data_o        = data_q;
   assign underflowError_o = und_q;

`ifdef FX3_SEQUENCE_CHECK_EN
   logic       seq_first_q;
   logic [9:0] seq_prev_q;
   logic       seq_err_q;

   // Sequence checker: each forwarded word must be previous+1 mod 2**10;
   // the first word of a burst only loads the comparator
   always_ff @(posedge fx3Clk_i or posedge reset_i) begin
      if (reset_i) begin
         seq_first_q <= 1'b0;
         seq_prev_q  <= '0;
         seq_err_q   <= 1'b0;
      end else if (state_q == S_IDLE && state_d == S_BURST) begin
         seq_first_q <= 1'b1;
      end else if (tap) begin
         seq_first_q <= 1'b0;
         seq_prev_q  <= fifoData_i[9:0];
         if (!seq_first_q && (fifoData_i[9:0] != seq_prev_q + 10'd1)) seq_err_q <= 1'b1;
      end
   end

   assign seqError_o = seq_err_q;
`endif

endmodule

// File: tb/tb_fx3_burst_reader.sv
// Testbench for fx3_burst_reader with a 16-word burst. Includes a FIFO model
// with two-cycle read latency, a cycle-stamped log of the DUT outputs, a
// vector table, hand-written corner sequences and a randomized scoreboard run.
module tb_fx3_burst_reader;

   localparam int BL = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        data_avail = 1'b0;
   logic        fx3_ready = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [15:0] fifo_data = '0;
   logic        read_data, fx3_wr, pkt_end, busy, und_err;
   logic [15:0] fx3_data;
   logic [1:0]  state;
`ifdef FX3_SEQUENCE_CHECK_EN
   logic        seq_err;
`endif

   fx3_burst_reader #(.BURST_LEN(BL), .READ_LATENCY(2), .CNT_W(5)) dut (
      .fx3Clk_i        (clk),
      .reset_i         (rst),
      .enable_i        (enable),
      .dataAvailable_i (data_avail),
      .fifoEmpty_i     (fifo_empty),
      .fifoData_i      (fifo_data),
      .fx3Ready_i      (fx3_ready),
      .readData_o      (read_data),
      .fx3Wr_o         (fx3_wr),
      .fx3Data_o       (fx3_data),
      .fx3PktEnd_o     (pkt_end),
      .busy_o          (busy),
      .underflowError_o(und_err),
`ifdef FX3_SEQUENCE_CHECK_EN
      .seqError_o      (seq_err),
`endif
      .state_o         (state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- FIFO model ----------------
   logic [15:0] fifo_mem[$];
   logic [15:0] fifo_s1 = '0;
   logic        rd_seen = 1'b0;

   // Word read at an edge is in the q register one cycle later and at the
   // converter output (fifo_data) the cycle after that.
   always @(posedge clk) begin
      #1;
      fifo_data = fifo_s1;
      if (rd_seen && fifo_mem.size() > 0) fifo_s1 = fifo_mem.pop_front();
      else                                fifo_s1 = 16'($urandom_range(0, 65535));
      fifo_empty = (fifo_mem.size() == 0);
   end

   // ---------------- output monitor ----------------
   int          rd_log[$];
   int          wr_log[$];
   int          pe_log[$];
   logic [15:0] wd_log[$];
   logic        sq_log[$];

   always @(negedge clk) begin
      rd_seen = read_data;
      if (read_data) rd_log.push_back(cyc);
      if (fx3_wr) begin
         wr_log.push_back(cyc);
         wd_log.push_back(fx3_data);
`ifdef FX3_SEQUENCE_CHECK_EN
         sq_log.push_back(seq_err);
`endif
      end
      if (pkt_end) pe_log.push_back(cyc);
   end

   // ---------------- scoreboard / checks ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- driver tasks (all end at negedge+1) ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      rd_log.delete(); wr_log.delete(); pe_log.delete();
      wd_log.delete(); sq_log.delete();
   endtask

   task automatic do_reset();
      step(1);
      rst = 1'b1; enable = 1'b0; data_avail = 1'b0; fx3_ready = 1'b0;
      fifo_mem.delete();
      step(2);
      rst = 1'b0;
      step(2);
   endtask

   task automatic preload(input int n, input int mode);
      fifo_mem.delete();
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         logic [15:0] w;
         w = (mode == 0) ? 16'($urandom_range(0, 65535)) : 16'(i * 7 + 100);
         fifo_mem.push_back(w);
         if (i < BL) exp_q.push_back(w);
      end
      step(2);
   endtask

   task automatic wait_busy(input logic want, input int max, input string name);
      int i = 0;
      while (busy !== want && i < max) begin
         step(1);
         i++;
      end
      check(name, busy, want);
   endtask

   task automatic check_data(input string name);
      check({name, "_count"}, wd_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check(name, (i < wd_log.size()) ? wd_log[i] : 16'hxxxx, exp_q[i]);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int   n_words;
      logic en;
      logic rdy;
      int   exp_wr;
      int   exp_pe;
      logic exp_und;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int c;
      logic und_model;

      vecs[0] = '{16, 1'b1, 1'b1, 16, 0, 1'b0};
      vecs[1] = '{20, 1'b1, 1'b1, 16, 0, 1'b0};
      vecs[2] = '{ 0, 1'b1, 1'b1,  0, 1, 1'b1};
      vecs[3] = '{ 1, 1'b1, 1'b1,  1, 1, 1'b1};
      vecs[4] = '{15, 1'b1, 1'b1, 15, 1, 1'b1};
      vecs[5] = '{10, 1'b0, 1'b1,  0, 0, 1'b0};
      vecs[6] = '{10, 1'b1, 1'b0,  0, 0, 1'b0};

      // ---- reset state ----
      do_reset();
      check("rst_readData", read_data, 0);
      check("rst_fx3Wr",    fx3_wr, 0);
      check("rst_fx3Data",  fx3_data, 0);
      check("rst_pktEnd",   pkt_end, 0);
      check("rst_busy",     busy, 0);
      check("rst_underflow", und_err, 0);
      check("rst_state",    state, 0);

      // ---- full burst: timing, order, no packet end ----
      preload(32, 1);
      clear_logs();
      c = cyc;
      enable = 1'b1; data_avail = 1'b1; fx3_ready = 1'b1;
      wait_busy(1'b1, 5, "full_start");
      fx3_ready = 1'b0;
      wait_busy(1'b0, 60, "full_done");
      step(3);
      check("full_rd_count", rd_log.size(), BL);
      check("full_rd_first", rd_log[0], c + 1);
      check("full_rd_consec", rd_log[BL-1] - rd_log[0], BL - 1);
      check("full_wr_lat", wr_log[0] - rd_log[0], 3);
      check("full_wr_consec", wr_log[BL-1] - wr_log[0], BL - 1);
      check("full_pktEnd", pe_log.size(), 0);
      check("full_underflow", und_err, 0);
      check_data("full_data");

      // ---- gating on fx3Ready ----
      do_reset();
      preload(20, 1);
      clear_logs();
      enable = 1'b1; data_avail = 1'b1; fx3_ready = 1'b0;
      step(50);
      check("gate_no_read", rd_log.size(), 0);
      check("gate_idle", busy, 0);
      c = cyc;
      fx3_ready = 1'b1;
      wait_busy(1'b1, 5, "gate_start");
      fx3_ready = 1'b0;
      wait_busy(1'b0, 60, "gate_done");
      step(3);
      check("gate_rd_first", rd_log[0], c + 1);
      check("gate_wr_count", wr_log.size(), BL);

      // ---- underflow after 5 words ----
      do_reset();
      preload(5, 1);
      clear_logs();
      enable = 1'b1; data_avail = 1'b1; fx3_ready = 1'b1;
      wait_busy(1'b1, 5, "und_start");
      fx3_ready = 1'b0;
      wait_busy(1'b0, 60, "und_done");
      step(10);
      check("und_rd_count", rd_log.size(), 5);
      check("und_flag", und_err, 1);
      check("und_pe_count", pe_log.size(), 1);
      check("und_pe_time", pe_log[0], wr_log[4] + 1);
      check_data("und_data");

      // ---- reset at word 7 (underflow flag still set from above) ----
      preload(32, 1);
      clear_logs();
      fx3_ready = 1'b1;
      wait_busy(1'b1, 5, "rmid_start");
      fx3_ready = 1'b0;
      for (int i = 0; i < 40 && rd_log.size() < 7; i++) step(1);
      check("rmid_at_word7", rd_log.size(), 7);
      check("rmid_und_before", und_err, 1);
      rst = 1'b1; enable = 1'b0;
      #1;
      check("rmid_readData", read_data, 0);
      check("rmid_fx3Wr", fx3_wr, 0);
      check("rmid_busy", busy, 0);
      check("rmid_underflow", und_err, 0);
      step(2);
      rst = 1'b0;
      data_avail = 1'b1; fx3_ready = 1'b1;
      step(5);
      check("rmid_state_idle", state, 0);
      check("rmid_busy_after", busy, 0);

      // ---- enable drop at word 4 ----
      do_reset();
      preload(40, 1);
      clear_logs();
      enable = 1'b1; data_avail = 1'b1; fx3_ready = 1'b1;
      for (int i = 0; i < 40 && rd_log.size() < 4; i++) step(1);
      enable = 1'b0;
      step(40);
      check("en_rd_count", rd_log.size(), BL);
      check("en_pktEnd", pe_log.size(), 0);
      check("en_idle", busy, 0);
      check_data("en_data");

      // ---- vector table ----
      foreach (vecs[v]) begin
         do_reset();
         preload(vecs[v].n_words, 0);
         clear_logs();
         enable = vecs[v].en; data_avail = 1'b1; fx3_ready = vecs[v].rdy;
         step(5);
         enable = 1'b0; fx3_ready = 1'b0;
         wait_busy(1'b0, 60, "vec_done");
         step(5);
         check($sformatf("vec%0d_wr", v), wr_log.size(), vecs[v].exp_wr);
         check($sformatf("vec%0d_pe", v), pe_log.size(), vecs[v].exp_pe);
         check($sformatf("vec%0d_und", v), und_err, vecs[v].exp_und);
      end

      // ---- randomized bursts against the reference model ----
      do_reset();
      und_model = 1'b0;
      for (int t = 0; t < 20; t++) begin
         int k;
         k = $urandom_range(0, 36);
         preload(k, 0);
         clear_logs();
         step($urandom_range(0, 5));
         data_avail = 1'b1; fx3_ready = 1'b1;
         step($urandom_range(0, 3));
         enable = 1'b1;
         wait_busy(1'b1, 5, "rand_start");
         enable = 1'b0; fx3_ready = 1'b0;
         wait_busy(1'b0, 80, "rand_done");
         step(3);
         if (k < BL) und_model = 1'b1;
         check_data("rand_data");
         check("rand_pe", pe_log.size(), (k < BL) ? 1 : 0);
         check("rand_und", und_err, und_model);
      end

`ifdef FX3_SEQUENCE_CHECK_EN
      // ---- sequence checker ----
      do_reset();
      fifo_mem.delete();
      fifo_mem.push_back(16'd0); fifo_mem.push_back(16'd1);
      fifo_mem.push_back(16'd2); fifo_mem.push_back(16'd4);
      step(2);
      clear_logs();
      enable = 1'b1; data_avail = 1'b1; fx3_ready = 1'b1;
      wait_busy(1'b1, 5, "seq_start");
      enable = 1'b0; fx3_ready = 1'b0;
      wait_busy(1'b0, 40, "seq_done");
      step(3);
      check("seq_wr_count", sq_log.size(), 4);
      check("seq_w1", sq_log[0], 0);
      check("seq_w2", sq_log[2], 0);
      check("seq_w4", sq_log[3], 1);
      check("seq_sticky", seq_err, 1);

      do_reset();
      fifo_mem.delete();
      fifo_mem.push_back(16'h03FF); fifo_mem.push_back(16'h0000);
      step(2);
      clear_logs();
      enable = 1'b1; data_avail = 1'b1; fx3_ready = 1'b1;
      wait_busy(1'b1, 5, "seqw_start");
      enable = 1'b0; fx3_ready = 1'b0;
      wait_busy(1'b0, 40, "seqw_done");
      step(3);
      check("seqw_wr_count", wr_log.size(), 2);
      check("seqw_no_err", seq_err, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
